// File: rtl/hash_resp_serializer.sv
// Hash-table read response serializer.
// Takes a batch of NUM_RD parallel read results (qualified by a lane mask)
// and emits the qualified lanes one per cycle, lowest lane first, over a
// valid/ready output. Batches offered while the block cannot take them are
// dropped and counted; emitted hits are counted.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. out_valid never waits on out_ready, and out_lane/out_data/
// out_last hold steady while out_valid is high and out_ready is low. The
// upstream side cannot stall: a batch offered while in_ready is low is lost.
module hash_resp_serializer #(
    parameter int NUM_RD     = 8,
    parameter int DATA_WIDTH = 64,
    parameter int LANE_W     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [NUM_RD-1:0]            in_lane_en,
    input  logic [NUM_RD*DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANE_W-1:0]            out_lane,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [15:0]                  drop_cnt,
    output logic [31:0]                  hit_cnt,
    output logic                         dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                         r_state;
    state_t                         w_next_state;
    logic [NUM_RD-1:0]              r_pending;
    logic [NUM_RD*DATA_WIDTH-1:0]   r_data;
    logic [15:0]                    r_drop_cnt;
    logic [31:0]                    r_hit_cnt;

    logic [LANE_W-1:0]              w_low_lane;
    logic [NUM_RD-1:0]              w_low_onehot;
    logic                           w_single;
    logic                           w_fire;
    logic                           w_load;
    logic                           w_drop;

    // Pick the lowest pending lane; scanning downward leaves the lowest index.
    always_comb begin
        w_low_lane = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_lane = LANE_W'(i);
            end
        end
    end

    assign w_low_onehot = NUM_RD'(1) << w_low_lane;
    // Exactly one bit pending: clearing the lowest bit leaves nothing.
    assign w_single     = (r_pending != '0) && ((r_pending & ~w_low_onehot) == '0);

    assign w_fire = out_valid && out_ready;
    assign w_load = in_valid && in_ready && (in_lane_en != '0);
    assign w_drop = in_valid && !in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a back-to-back load on the final handshake keeps DRAIN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_fire && w_single) begin
                    w_next_state = w_load ? S_DRAIN : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: only state, out_ready and pending feed in_ready.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                in_ready  = out_ready && w_single;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b0;
            end
        endcase
    end

    // Batch register and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_data     <= '0;
            r_drop_cnt <= '0;
            r_hit_cnt  <= '0;
        end else begin
            if (w_load) begin
                r_pending <= in_lane_en;
                r_data    <= in_data;
            end else if (w_fire) begin
                r_pending <= r_pending & ~w_low_onehot;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_fire && out_data[DATA_WIDTH-1]) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
        end
    end

    // Serialized result comes only from latched state; zero while idle.
    always_comb begin
        out_lane = '0;
        out_data = '0;
        out_last = 1'b0;
        if (r_state == S_DRAIN) begin
            out_lane = w_low_lane;
            out_data = r_data[w_low_lane*DATA_WIDTH +: DATA_WIDTH];
            out_last = w_single;
        end
    end

    assign drop_cnt  = r_drop_cnt;
    assign hit_cnt   = r_hit_cnt;
    assign dbg_state = r_state;

endmodule

// File: doc/hash_resp_serializer.md
HASH_RESP_SERIALIZER -- requirements
Module: hash_resp_serializer

Interface
REQ-001 Parameter NUM_RD, default 8: number of hash-table read lanes per batch (power of 2, 2..16).
REQ-002 Parameter DATA_WIDTH, default 64: width of one lane's read word; bit DATA_WIDTH-1 is the hit flag.
REQ-003 Parameter LANE_W, default 3: lane index width, equal to log2(NUM_RD).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  batch of read results presented this cycle.
REQ-007 in_lane_en  input  NUM_RD  per-lane result-valid mask; bit i qualifies lane i.
REQ-008 in_data  input  NUM_RD*DATA_WIDTH  packed read words; lane i occupies bits i*DATA_WIDTH +: DATA_WIDTH.
REQ-009 in_ready  output  1  batch accepted when in_valid and in_ready are both high.
REQ-010 out_valid  output  1  serialized result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_lane  output  LANE_W  lane index of out_data.
REQ-013 out_data  output  DATA_WIDTH  read word for out_lane.
REQ-014 out_last  output  1  high when out_data is the final pending lane of the batch.
REQ-015 drop_cnt  output  16  count of batches lost to back-pressure.
REQ-016 hit_cnt  output  32  count of emitted results with the hit flag set.

Function
REQ-017 The block SHALL have two states, IDLE and DRAIN, and SHALL hold one batch register (data plus pending mask).
REQ-018 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-019 An accepted batch with a nonzero in_lane_en SHALL be latched with pending=in_lane_en, and the FSM SHALL enter DRAIN; out_valid SHALL rise on the cycle after acceptance (1-cycle latency).
REQ-020 An accepted batch with in_lane_en==0 SHALL be consumed with no output, and the FSM SHALL stay in IDLE.
REQ-021 In DRAIN, out_valid SHALL be 1, out_lane SHALL be the lowest set bit of pending, and out_data SHALL be that lane's latched word.
REQ-022 In DRAIN, out_last SHALL be 1 exactly when pending has one bit set.
REQ-023 out_lane, out_data and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-024 On an output handshake, the emitted lane's pending bit SHALL clear; if out_last was high, the FSM SHALL return to IDLE.
REQ-025 The output SHALL sustain one result per cycle while out_ready is held high.
REQ-026 in_ready SHALL be high in IDLE, or in DRAIN when out_valid, out_ready and out_last are all high; a batch offered in that cycle SHALL be latched, and DRAIN SHALL continue with no idle bubble.
REQ-027 The upstream hash table cannot stall, so in_valid while in_ready is low SHALL discard that batch and increment drop_cnt, saturating at 16'hFFFF.
REQ-028 hit_cnt SHALL increment by 1 on each output handshake whose out_data[DATA_WIDTH-1] is 1, wrapping modulo 2^32.
REQ-029 out_valid, out_lane, out_data and out_last SHALL be driven from registers or latched state, with no combinational path from in_* to out_*.
REQ-030 in_ready SHALL depend combinationally only on state, out_ready and pending.

Reset
REQ-031 While reset is high, the block SHALL hold state=IDLE, pending=0, out_valid=0, out_lane=0, out_data=0, out_last=0, drop_cnt=0 and hit_cnt=0; in_ready SHALL be 1 on the cycle after reset is released.
REQ-032 A reset asserted during DRAIN SHALL abandon the batch without emitting its remaining lanes, and without counting them as drops.
REQ-033 Inputs SHALL be ignored on every cycle where reset is high.

Verification
REQ-034 in_lane_en=8'b1010_0101, lane i data = {1'b(i odd),63'(i)}, out_ready=1 -> lanes 0,2,5,7 emitted on 4 consecutive cycles; out_last only on lane 7; hit_cnt=2.
REQ-035 in_lane_en=8'hFF, out_ready toggling 1,0,1,0 -> 8 results in lane order 0..7, outputs stable during stall cycles, no drops.
REQ-036 Second batch (en=8'h03) offered during the cycle lane 7 of the first batch (en=8'h80) handshakes -> accepted; the lane-0 result follows with no gap; drop_cnt=0.
REQ-037 Batch offered while 3 lanes are still pending -> drop_cnt increments to 1; 70000 such drops -> drop_cnt=16'hFFFF.
REQ-038 in_valid with in_lane_en=0 -> no out_valid; state stays IDLE; in_ready stays 1.
REQ-039 reset pulsed after 2 of 8 lanes have been emitted -> out_valid=0 on the next cycle, counters=0; a new batch (en=8'h10) then emits lane 4 only.
